// File: rtl/custom_stream_rx.sv
// Custom stream slave receiver: checks per-frame address sequencing and buffers words
// in a store-and-forward FIFO so only complete, error-free frames reach the consumer.
module custom_stream_rx #(
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 cs_addr,
  input  logic [31:0]                 cs_data,
  input  logic                        cs_fs,
  input  logic                        cs_user_i,
  output logic                        cs_user_o,
  output logic                        cs_user_oe,
  output logic [31:0]                 m_data,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [15:0]                 frames_ok,
  output logic [15:0]                 frames_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRecv, StDrop} state_e;

  state_e        state_q, state_d;
  logic [31:0]   exp_q, exp_d;
  logic [PW-1:0] wp_q, wp_d, cp_q, cp_d, rp_q;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [15:0]   ok_q, err_q;
  logic          pulse_q;

  logic          we, wlast, start, err, commit, full, start_full, rd;
  logic [AW-1:0] waddr;
  logic          unused_cs_user;

  assign unused_cs_user = cs_user_i;

  // wp - rp counts committed plus in-flight words; a new frame only sees committed ones.
  assign full       = (wp_q - rp_q) == PW'(FIFO_DEPTH);
  assign start_full = (cp_q - rp_q) == PW'(FIFO_DEPTH);

  assign m_valid    = cp_q != rp_q;
  assign rd         = m_valid & m_ready;
  assign m_data     = m_valid ? mem[rp_q[AW-1:0]][31:0] : 32'd0;
  assign m_last     = m_valid & mem[rp_q[AW-1:0]][32];
  assign fifo_level = cp_q - rp_q;
  assign cs_user_o  = pulse_q;
  assign cs_user_oe = pulse_q;
  assign frames_ok  = ok_q;
  assign frames_err = err_q;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    wp_d    = wp_q;
    cp_d    = cp_q;
    we      = 1'b0;
    wlast   = 1'b0;
    waddr   = wp_q[AW-1:0];
    start   = 1'b0;
    err     = 1'b0;
    commit  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_fs) begin
          if (cs_addr == 32'd0) start = 1'b1;
          else                  err   = 1'b1;
        end
      end
      StRecv: begin
        if (cs_fs) begin
          err  = 1'b1;
          wp_d = cp_q;
          if (cs_addr == 32'd0) start   = 1'b1;
          else                  state_d = StDrop;
        end else if (cs_addr == exp_q && !full) begin
          we    = 1'b1;
          wp_d  = wp_q + PW'(1);
          exp_d = exp_q + 32'd1;
          if (exp_q == 32'(FRAME_LEN - 1)) begin
            wlast   = 1'b1;
            cp_d    = wp_q + PW'(1);
            commit  = 1'b1;
            exp_d   = 32'd0;
            state_d = StIdle;
          end
        end else if (cs_addr != exp_q - 32'd1) begin
          err     = 1'b1;
          wp_d    = cp_q;
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (cs_fs && cs_addr == 32'd0) start = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Word 0 of a new frame always lands at cp; with no room the frame is dropped.
    if (start) begin
      if (start_full) begin
        err     = 1'b1;
        state_d = StDrop;
      end else begin
        we      = 1'b1;
        waddr   = cp_q[AW-1:0];
        wp_d    = cp_q + PW'(1);
        exp_d   = 32'd1;
        state_d = StRecv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      exp_q   <= 32'd0;
      wp_q    <= '0;
      cp_q    <= '0;
      rp_q    <= '0;
      ok_q    <= 16'd0;
      err_q   <= 16'd0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      wp_q    <= wp_d;
      cp_q    <= cp_d;
      rp_q    <= rp_q + PW'(rd);
      pulse_q <= err;
      if (commit && ok_q != 16'hFFFF) ok_q <= ok_q + 16'd1;
      if (err && err_q != 16'hFFFF)   err_q <= err_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= {wlast, cs_data};
  end

endmodule

// File: tb/tb_custom_stream_rx.sv
// Bench for custom_stream_rx: directed scenario table, reset corner case, and random
// traffic compared every cycle against a queue-based frame model.
module tb_custom_stream_rx;

  localparam int FL = 16;
  localparam int FD = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cs_addr, cs_data;
  logic        cs_fs, cs_user_i, cs_user_o, cs_user_oe;
  logic [31:0] m_data;
  logic        m_last, m_valid, m_ready;
  logic [15:0] frames_ok, frames_err;
  logic [5:0]  fifo_level;

  always #5 clk = ~clk;

  custom_stream_rx #(.FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .cs_addr(cs_addr), .cs_data(cs_data), .cs_fs(cs_fs),
    .cs_user_i(cs_user_i), .cs_user_o(cs_user_o), .cs_user_oe(cs_user_oe),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .frames_ok(frames_ok), .frames_err(frames_err), .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: committed words, words of the frame in progress, frame status.
  typedef struct packed {logic last; logic [31:0] data;} ent_t;
  ent_t        commq[$];
  logic [31:0] pend[$];
  bit          in_frame, dropping, m_pulse;
  int          m_ok, m_err;

  int outs, lasts, pulses;
  bit rnd_ready;
  int rdy_pct;

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  task automatic model_reset();
    commq.delete(); pend.delete();
    in_frame = 0; dropping = 0; m_pulse = 0; m_ok = 0; m_err = 0;
  endtask

  task automatic model_step(input bit fs, input logic [31:0] addr, input logic [31:0] data,
                            input bit rdy);
    bit e, full, cfull, rd, start, do_commit;
    e = 0; start = 0; do_commit = 0;
    full  = (commq.size() + pend.size()) == FD;
    cfull = commq.size() == FD;
    rd    = (commq.size() != 0) && rdy;
    if (!in_frame) begin
      if (fs && addr == 0) start = 1;
      else if (fs && !dropping) e = 1;
    end else if (fs) begin
      e = 1;
      pend.delete();
      if (addr == 0) start = 1;
      else begin in_frame = 0; dropping = 1; end
    end else if (addr == 32'(pend.size()) && !full) begin
      pend.push_back(data);
      if (pend.size() == FL) do_commit = 1;
    end else if (addr != 32'(pend.size() - 1)) begin
      e = 1;
      pend.delete();
      in_frame = 0; dropping = 1;
    end
    if (start) begin
      if (cfull) begin e = 1; in_frame = 0; dropping = 1; end
      else begin pend.delete(); pend.push_back(data); in_frame = 1; dropping = 0; end
    end
    if (rd) void'(commq.pop_front());
    if (do_commit) begin
      for (int i = 0; i < FL; i++) commq.push_back('{last: (i == FL - 1), data: pend[i]});
      pend.delete();
      in_frame = 0;
      m_ok++;
    end
    if (e) m_err++;
    m_pulse = e;
  endtask

  task automatic check_outputs();
    bit          ev;
    logic [31:0] ed;
    logic        el;
    ev = commq.size() != 0;
    ed = ev ? commq[0].data : 32'd0;
    el = ev ? commq[0].last : 1'b0;
    checks++;
    if (m_valid !== ev || (ev && (m_data !== ed || m_last !== el)) ||
        cs_user_o !== m_pulse || cs_user_oe !== m_pulse || frames_ok !== sat16(m_ok) ||
        frames_err !== sat16(m_err) || fifo_level !== 6'(commq.size())) begin
      errors++;
      $display("FAIL cycle t=%0t: got v=%b d=%h l=%b u=%b oe=%b ok=%0d err=%0d lvl=%0d; want v=%b d=%h l=%b u=%b ok=%0d err=%0d lvl=%0d",
               $time, m_valid, m_data, m_last, cs_user_o, cs_user_oe, frames_ok, frames_err,
               fifo_level, ev, ed, el, m_pulse, m_ok, m_err, commq.size());
    end
  endtask

  task automatic step(input bit fs, input logic [31:0] addr);
    cs_fs = fs; cs_addr = addr; cs_data = 32'hA0 + addr; cs_user_i = 1'($urandom);
    if (rnd_ready) m_ready = ($urandom_range(0, 99) < rdy_pct);
    // Every committed frame carries 0xA0+index, so the output stream has a fixed shape.
    if (m_valid && m_ready) begin
      checks++;
      if (m_data !== 32'hA0 + 32'(outs % FL) || m_last !== ((outs % FL) == FL - 1)) begin
        errors++;
        $display("FAIL out_word %0d: got d=%h l=%b want d=%h l=%b", outs, m_data, m_last,
                 32'hA0 + 32'(outs % FL), (outs % FL) == FL - 1);
      end
      outs++;
      if (m_last) lasts++;
    end
    model_step(fs, addr, 32'hA0 + addr, m_ready);
    @(posedge clk); #1;
    if (cs_user_o) pulses++;
    check_outputs();
  endtask

  task automatic send(input int from, input int to);
    for (int i = from; i <= to; i++) step(i == 0, 32'(i));
  endtask

  task automatic do_reset();
    rst = 1; cs_fs = 0; cs_addr = 0; cs_data = 0; cs_user_i = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    outs = 0; lasts = 0; pulses = 0;
    check_outputs();
  endtask

  task automatic drain();
    m_ready = 1;
    for (int i = 0; i < 2 * FD + 4; i++) step(0, 32'd0);
  endtask

  typedef struct {int kind; int ok; int err; int outs; int lasts; int pulses;} vec_t;
  vec_t tbl[5];

  initial begin
    rnd_ready = 0; rdy_pct = 100; m_ready = 1;
    tbl[0] = '{0, 1, 0, 16, 1, 0};  // clean
    tbl[1] = '{1, 1, 0, 16, 1, 0};  // hold cycles
    tbl[2] = '{2, 1, 1, 16, 1, 1};  // sequence error, then clean
    tbl[3] = '{3, 1, 1, 16, 1, 1};  // premature frame sync
    tbl[4] = '{4, 2, 1, 32, 2, 1};  // overflow

    for (int t = 0; t < 5; t++) begin
      m_ready = (tbl[t].kind != 4);
      do_reset();
      case (tbl[t].kind)
        0: send(0, 15);
        1: begin
          step(1, 0); step(0, 1); step(0, 1); step(0, 1); send(2, 15);
        end
        2: begin send(0, 5); step(0, 9); send(0, 15); end
        3: begin send(0, 7); send(0, 15); end
        default: begin
          send(0, 15); send(0, 15); send(0, 15);
          checks++;
          if (fifo_level !== 6'd32 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL ovf_level: got lvl=%0d v=%b want lvl=32 v=1", fifo_level, m_valid);
          end
        end
      endcase
      drain();
      checks += 5;
      if (frames_ok !== 16'(tbl[t].ok)) begin
        errors++; $display("FAIL tbl%0d_ok: got %0d want %0d", t, frames_ok, tbl[t].ok);
      end
      if (frames_err !== 16'(tbl[t].err)) begin
        errors++; $display("FAIL tbl%0d_err: got %0d want %0d", t, frames_err, tbl[t].err);
      end
      if (outs != tbl[t].outs) begin
        errors++; $display("FAIL tbl%0d_outs: got %0d want %0d", t, outs, tbl[t].outs);
      end
      if (lasts != tbl[t].lasts) begin
        errors++; $display("FAIL tbl%0d_lasts: got %0d want %0d", t, lasts, tbl[t].lasts);
      end
      if (pulses != tbl[t].pulses) begin
        errors++; $display("FAIL tbl%0d_pulses: got %0d want %0d", t, pulses, tbl[t].pulses);
      end
    end

    // Reset while receiving, with a committed frame still unread.
    m_ready = 0;
    do_reset();
    send(0, 15);
    send(0, 7);
    do_reset();
    checks++;
    if (m_valid !== 0 || m_data !== 0 || m_last !== 0 || fifo_level !== 0 ||
        frames_ok !== 0 || frames_err !== 0 || cs_user_o !== 0 || cs_user_oe !== 0) begin
      errors++;
      $display("FAIL reset_mid: got v=%b d=%h l=%b lvl=%0d ok=%0d err=%0d u=%b want all 0",
               m_valid, m_data, m_last, fifo_level, frames_ok, frames_err, cs_user_o);
    end
    m_ready = 1;
    send(0, 15);
    drain();

    // Random traffic against the model.
    do_reset();
    rnd_ready = 1;
    for (int f = 0; f < 120; f++) begin
      int kind, cut;
      rdy_pct = ($urandom_range(0, 3) == 0) ? 10 : 75;
      kind = $urandom_range(0, 5);
      cut  = $urandom_range(1, FL - 1);
      case (kind)
        3: begin send(0, cut - 1); step(0, 32'(cut + $urandom_range(1, 5))); end
        4: send(0, cut - 1);
        5: step(1, 32'($urandom_range(1, 40)));
        default: begin
          for (int i = 0; i < FL; i++) begin
            step(i == 0, 32'(i));
            if (i > 0 && $urandom_range(0, 4) == 0) step(0, 32'(i));
          end
        end
      endcase
      if (kind != 4) begin
        for (int g = $urandom_range(0, 3); g > 0; g--) step(0, 32'($urandom_range(0, 20)));
      end
    end
    rnd_ready = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/custom_stream_rx.md
# custom_stream_rx

Slave-end receiver for the custom stream interface (cs_addr, cs_data, cs_fs, cs_user). It checks the address sequence of each frame and buffers the words in a store-and-forward FIFO. Only complete, error-free frames are released to a downstream valid/ready consumer. Frame errors are signalled back to the master on cs_user, and good and bad frames are counted for status registers.

## Interface
- FRAME_LEN, 16: words per frame; must be ≥ 2.
- FIFO_DEPTH, 32: FIFO entries; power of 2; must be ≥ FRAME_LEN.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cs_addr  in  32  word index within the frame.
- cs_data  in  32  word payload.
- cs_fs  in  1  frame sync; high with the first word of a frame.
- cs_user_i  in  1  cs_user input; read only, no effect on behaviour.
- cs_user_o  out  1  error pulse driven back to the master.
- cs_user_oe  out  1  output enable for cs_user; high only while cs_user_o is driven.
- m_data  out  32  output word.
- m_last  out  1  high on the last word of a frame.
- m_valid  out  1  output word available.
- m_ready  in  1  consumer accepts the word; transfer occurs when m_valid & m_ready.
- frames_ok  out  16  count of committed frames; saturates at 0xFFFF.
- frames_err  out  16  count of errored or dropped frames; saturates at 0xFFFF.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  committed words not yet read.

## Operation
- Internal state: states IDLE, RECV and DROP; expected index `exp`; FIFO entries of 33 bits ({last, data}).
- Pointers: write pointer `wp`, commit pointer `cp`, read pointer `rp`, each $clog2(FIFO_DEPTH)+1 bits and wrapping modulo 2·FIFO_DEPTH.
- Full condition: wp − rp == FIFO_DEPTH.
- IDLE:
  - cs_fs=1 & cs_addr=0: write the word, set exp=1, go to RECV.
  - cs_fs=1 & cs_addr≠0: frame error, stay in IDLE.
  - Otherwise: ignore the input.
- RECV, evaluated in priority order:
  1. cs_fs=1 (premature start): the current frame is an error and wp rewinds to cp. If cs_addr=0 the new frame's word 0 is written in the same cycle (written at cp) with exp=1 and state stays RECV; otherwise go to DROP.
  2. cs_addr==exp and FIFO not full: write the word, exp++. If exp==FRAME_LEN−1 the word is written with last=1, cp takes the new wp, frames_ok++, go to IDLE.
  3. cs_addr==exp−1: hold cycle; nothing is written.
  4. cs_addr==exp with FIFO full (overflow), or any other cs_addr (sequence error): frame error, wp rewinds to cp, go to DROP.
- DROP: ignore all input until cs_fs=1 & cs_addr=0, which starts a new frame in that same cycle exactly as from IDLE.
- Each frame error increments frames_err by 1. At most one increment per cycle.
- cs_user_o and cs_user_oe are both high for exactly the one cycle after an error is detected, and 0 otherwise. Back-to-back errors produce back-to-back pulses.
- Read side:
  - m_valid = (cp ≠ rp).
  - m_data and m_last show the entry at rp (first-word fall-through).
  - rp increments on m_valid & m_ready.
- Rewinds only move wp and never touch rp or cp, so committed data is never lost.
- fifo_level = cp − rp.

## Timing
- Reset: state=IDLE; wp, cp, rp, exp = 0; m_valid, m_last, m_data, cs_user_o, cs_user_oe, frames_ok, frames_err, fifo_level all 0.
- Reset mid-frame discards all data, including committed unread frames.
- Word accepted at edge N → written at edge N.
- Last word accepted at edge N → m_valid=1 and fifo_level updated in cycle N+1. Minimum latency from last word to output is 1 cycle.
- Error detected in cycle N → cs_user_o/cs_user_oe high in cycle N+1; frames_err updated at edge N.
- A commit and a read in the same cycle: fifo_level = old + FRAME_LEN − 1.
- A rewind and a read in the same cycle are independent.
- Full is evaluated against the current rp. A read in the same cycle does not free space for that cycle's write.
- m_data and m_last are stable while m_valid=1 and m_ready=0.

## Test plan
- Clean frame: FRAME_LEN=16, addr 0..15 with data 0xA0+i, cs_fs on addr 0, m_ready=1 → 16 outputs with data 0xA0..0xAF, m_last only on 0xAF, frames_ok=1, no cs_user pulse.
- Hold cycles: addr 0,1,1,1,2..15 → exactly 16 words written; output identical to the clean frame.
- Sequence error: addr 0..5 then 9 → no output, frames_err=1, cs_user_o one-cycle pulse, fifo_level unchanged; a following clean frame is output intact.
- Premature cs_fs: addr 0..7 then cs_fs with addr 0 and a full frame → frames_err=1, frames_ok=1, only the second frame is output (16 words).
- Overflow: FIFO_DEPTH=32, m_ready=0, send 3 frames → frames 1–2 committed (fifo_level=32), frame 3 dropped at word 0, frames_err=1. Raise m_ready → 32 words out, m_last on words 16 and 32.
- Reset during RECV after 8 words, with one committed frame pending → all outputs 0 on the next cycle, m_valid=0, counters 0.
